// File: rtl/fifo_unpack_pkg.sv
// -----------------------------------------------------------------------------
// fifo_unpack_pkg
// Shared configuration helpers for the fifo_unpack width-down-converter:
//   - cfg_ok()   : legality check used at elaboration
//                  (IN_WIDTH multiple of OUT_WIDTH, at least 2 beats per word)
//   - cnt_bits() : width of the beat index for a given beats-per-word ratio
// Optional feature macro used by the importing files: FIFO_UNPACK_LAST_EN
// -----------------------------------------------------------------------------
package fifo_unpack_pkg;

    localparam int DEF_IN_WIDTH  = 128;
    localparam int DEF_OUT_WIDTH = 32;

    function automatic bit cfg_ok(input int in_w, input int out_w);
        return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
    endfunction

    function automatic int cnt_bits(input int ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_unpack_if.sv
// -----------------------------------------------------------------------------
// fifo_unpack_if
// Bundles the FIFO-side and stream-side signals of fifo_unpack.
//   fifo_dout / fifo_empty / fifo_pop : FWFT FIFO read port
//   out_valid / out_ready / out_data  : narrow output stream
//   busy                              : a word is held in the unpacker
//   out_last (FIFO_UNPACK_LAST_EN)    : final beat of each FIFO word
// Modports: master = the unpacker, slave = FIFO + downstream consumer.
// -----------------------------------------------------------------------------
interface fifo_unpack_if #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32
);
    logic [IN_WIDTH-1:0]  fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 busy;
`ifdef FIFO_UNPACK_LAST_EN
    logic                 out_last;
`endif

    modport master (
        input  fifo_dout, fifo_empty, out_ready,
        output fifo_pop, out_valid, out_data, busy
`ifdef FIFO_UNPACK_LAST_EN
        , output out_last
`endif
    );

    modport slave (
        output fifo_dout, fifo_empty, out_ready,
        input  fifo_pop, out_valid, out_data, busy
`ifdef FIFO_UNPACK_LAST_EN
        , input out_last
`endif
    );
endinterface

// File: rtl/fifo_unpack.sv
// -----------------------------------------------------------------------------
// fifo_unpack
// Drains a first-word-fall-through FIFO and serialises each IN_WIDTH word into
// IN_WIDTH/OUT_WIDTH beats, least-significant slice first, at one beat/clock
// with no bubble between consecutive words.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   flush  : synchronously drop the partially sent word (FIFO untouched)
//   bus    : fifo_unpack_if.master (FIFO read port, output stream, busy)
// Optional: define FIFO_UNPACK_LAST_EN to drive bus.out_last on the final
//           beat of every word.
// -----------------------------------------------------------------------------
module fifo_unpack
    import fifo_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    fifo_unpack_if.master bus
);

    localparam int RATIO    = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_BITS = cnt_bits(RATIO);

    typedef logic [CNT_BITS-1:0] beat_idx_t;

    if (!cfg_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_cfg
        $error("fifo_unpack: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    logic [IN_WIDTH-1:0]                r_hold_data;
    logic                               r_hold_vld;
    beat_idx_t                          r_beat_cnt;
    logic                               r_en;

    logic                               w_accept;
    logic                               w_last;
    logic                               w_pop;
    logic [RATIO-1:0][OUT_WIDTH-1:0]    w_slices;

    assign w_accept = r_hold_vld & bus.out_ready;
    assign w_last   = (r_beat_cnt == beat_idx_t'(RATIO - 1));

    // Reload from the FIFO either when idle or on the same edge the final beat
    // leaves, which is what keeps back-to-back words bubble-free. r_en keeps
    // the pop quiet during reset and the release cycle.
    assign w_pop = r_en & ~bus.fifo_empty & ~flush &
                   (~r_hold_vld | (w_accept & w_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data <= '0;
            r_hold_vld  <= 1'b0;
            r_beat_cnt  <= '0;
            r_en        <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (flush) begin
                // Flush wins over any handshake in the same cycle.
                r_hold_vld <= 1'b0;
                r_beat_cnt <= '0;
            end else if (w_pop) begin
                r_hold_data <= bus.fifo_dout;
                r_hold_vld  <= 1'b1;
                r_beat_cnt  <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_hold_vld <= 1'b0;
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + beat_idx_t'(1);
                end
            end
        end
    end

    // View the held word as RATIO beats; index 0 is the LS slice.
    assign w_slices = r_hold_data;

    assign bus.fifo_pop  = w_pop;
    assign bus.out_valid = r_hold_vld;
    assign bus.out_data  = w_slices[r_beat_cnt];
    assign bus.busy      = r_hold_vld;

`ifdef FIFO_UNPACK_LAST_EN
    assign bus.out_last  = r_hold_vld & w_last;
`endif

endmodule

// File: tb/tb_fifo_unpack.sv
module tb_fifo_unpack;

    localparam int IW = 128;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic rdy = 1'b0;

    always #5 clk = ~clk;

    fifo_unpack_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    fifo_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.master)
    );

    // Small FWFT FIFO model standing in for fifo_cp: pushes from the stimulus
    // at the falling edge, pops on the rising edge when the unpacker asks.
    logic [IW-1:0] mem [0:15];
    int wp = 0;
    int rp = 0;

    assign bus.fifo_empty = (rp == wp);
    assign bus.fifo_dout  = mem[rp[3:0]];
    assign bus.out_ready  = rdy;

    always @(posedge clk) if (bus.fifo_pop) rp <= rp + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit            push;
        logic [IW-1:0] w;
        bit            rdy;
        bit            fl;
        bit            ev;
        logic [OW-1:0] ed;
        bit            ep;
        bit            el;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit push, input logic [IW-1:0] w, input bit r, input bit fl,
                       input bit ev, input logic [OW-1:0] ed, input bit ep, input bit el);
        vec_t v;
        v.push = push; v.w = w; v.rdy = r; v.fl = fl;
        v.ev = ev; v.ed = ed; v.ep = ep; v.el = el;
        tv.push_back(v);
    endtask

    task automatic check_outs(input string tag, input bit ev, input logic [OW-1:0] ed,
                              input bit ep, input bit el, input bit chk_data);
        chk({tag, ".valid"}, OW'(bus.out_valid), OW'(ev));
        chk({tag, ".busy"},  OW'(bus.busy),      OW'(ev));
        chk({tag, ".pop"},   OW'(bus.fifo_pop),  OW'(ep));
        if (chk_data) chk({tag, ".data"}, bus.out_data, ed);
`ifdef FIFO_UNPACK_LAST_EN
        chk({tag, ".last"}, OW'(bus.out_last), OW'(el));
`else
        if (el) begin end
`endif
    endtask

    localparam logic [IW-1:0] W0 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [IW-1:0] W1 = 128'h77777777_66666666_55555555_44444444;
    localparam logic [IW-1:0] W2 = 128'hbbbbbbbb_aaaaaaaa_99999999_88888888;
    localparam logic [IW-1:0] W3 = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
    localparam logic [IW-1:0] WA = 128'hA0000003_A0000002_A0000001_A0000000;
    localparam logic [IW-1:0] WB = 128'hB0000003_B0000002_B0000001_B0000000;

    initial begin
        // push, word, rdy, flush | valid, data, pop, last
        // single word, ready held high
        add(1, W0, 1, 0,  0, 32'h0,        1, 0);
        add(0, '0, 1, 0,  1, 32'h00000000, 0, 0);
        add(0, '0, 1, 0,  1, 32'h11111111, 0, 0);
        add(0, '0, 1, 0,  1, 32'h22222222, 0, 0);
        add(0, '0, 1, 0,  1, 32'h33333333, 0, 1);
        add(0, '0, 1, 0,  0, 32'h0,        0, 0);
        // two words back-to-back: pops 4 cycles apart, no bubble
        add(1, W1, 1, 0,  0, 32'h0,        1, 0);
        add(1, W2, 1, 0,  1, 32'h44444444, 0, 0);
        add(0, '0, 1, 0,  1, 32'h55555555, 0, 0);
        add(0, '0, 1, 0,  1, 32'h66666666, 0, 0);
        add(0, '0, 1, 0,  1, 32'h77777777, 1, 1);
        add(0, '0, 1, 0,  1, 32'h88888888, 0, 0);
        add(0, '0, 1, 0,  1, 32'h99999999, 0, 0);
        add(0, '0, 1, 0,  1, 32'haaaaaaaa, 0, 0);
        add(0, '0, 1, 0,  1, 32'hbbbbbbbb, 0, 1);
        add(0, '0, 1, 0,  0, 32'h0,        0, 0);
        // backpressure: ready 1,0,0,1 holds beat 1 for three cycles
        add(1, W3, 1, 0,  0, 32'h0,        1, 0);
        add(0, '0, 1, 0,  1, 32'hcccccccc, 0, 0);
        add(0, '0, 0, 0,  1, 32'hdddddddd, 0, 0);
        add(0, '0, 0, 0,  1, 32'hdddddddd, 0, 0);
        add(0, '0, 1, 0,  1, 32'hdddddddd, 0, 0);
        add(0, '0, 1, 0,  1, 32'heeeeeeee, 0, 0);
        add(0, '0, 1, 0,  1, 32'hffffffff, 0, 1);
        add(0, '0, 1, 0,  0, 32'h0,        0, 0);
        // flush after beat 1 of A with B queued
        add(1, WA, 1, 0,  0, 32'h0,        1, 0);
        add(1, WB, 1, 0,  1, 32'hA0000000, 0, 0);
        add(0, '0, 1, 0,  1, 32'hA0000001, 0, 0);
        add(0, '0, 0, 1,  1, 32'hA0000002, 0, 0);
        add(0, '0, 1, 0,  0, 32'h0,        1, 0);
        add(0, '0, 1, 0,  1, 32'hB0000000, 0, 0);
        add(0, '0, 1, 0,  1, 32'hB0000001, 0, 0);
        add(0, '0, 1, 0,  1, 32'hB0000002, 0, 0);
        add(0, '0, 1, 0,  1, 32'hB0000003, 0, 1);
        add(0, '0, 1, 0,  0, 32'h0,        0, 0);
        // lead-in for the reset-mid-word sequence: send beats 0..2 of W0, W1 queued
        add(1, W0, 1, 0,  0, 32'h0,        1, 0);
        add(1, W1, 1, 0,  1, 32'h00000000, 0, 0);
        add(0, '0, 1, 0,  1, 32'h11111111, 0, 0);
        add(0, '0, 1, 0,  1, 32'h22222222, 0, 0);

        // reset state
        @(negedge clk);
        @(negedge clk); #1;
        check_outs("reset", 0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            if (tv[i].push) begin
                mem[wp[3:0]] = tv[i].w;
                wp = wp + 1;
            end
            rdy   = tv[i].rdy;
            flush = tv[i].fl;
            #1;
            check_outs($sformatf("vec%0d", i), tv[i].ev, tv[i].ed, tv[i].ep, tv[i].el, tv[i].ev);
        end

        // reset asserted mid-word after beat 2: outputs clear at once
        @(negedge clk);
        flush = 1'b0;
        rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        check_outs("rst_mid", 0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("rst_release", 0, 32'h0, 0, 0, 0);
        @(negedge clk); #1;
        check_outs("rst_pop", 0, 32'h0, 1, 0, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); #1;
            check_outs($sformatf("resume%0d", j), 1, 32'h44444444 + 32'h11111111 * j, 0, j == 3, 1);
        end
        @(negedge clk); #1;
        check_outs("resume_end", 0, 32'h0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
